// File: rtl/axi_state_tx.sv
// Purpose: AXI-Stream transmitter that captures a 5x5x64 Keccak state and streams it LSB-first.
// Latency: first beat valid one cycle after start; done pulses the cycle after the last handshake.
// Backpressure: beat held stable while M_TREADY is low; start is ignored while a frame is in flight.
module axi_state_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_BITS   = 1600
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic [4:0][4:0][63:0] D_in,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic                  M_TLAST,
    output logic                  busy,
    output logic                  done
);

    // Full Keccak state width; the frame only drains the low OUT_BITS of it.
    localparam int STATE_BITS = 1600;
    localparam int BEATS      = OUT_BITS / DATA_WIDTH;
    localparam int CNT_W      = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [STATE_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic                    sending;
    logic                    last_beat;
    logic                    handshake;

    // Decode of the current beat position and the AXI transfer condition.
    always_comb begin
        sending   = (state_q == SEND);
        last_beat = (cnt_q == LAST_CNT);
        handshake = sending && M_TREADY;
    end

    // Next-state logic: capture on start from IDLE, shift one beat per handshake,
    // return to IDLE and raise done after the final beat is accepted.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Packed D_in already places lane [x][y] at bit 64*(5x+y).
                if (start) begin
                    shreg_d = D_in;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A start pulse here (even on the final handshake) is deliberately dropped.
                if (handshake) begin
                    shreg_d = shreg_q >> DATA_WIDTH;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset; reset aborts any frame silently.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from flops so they stay stable while the sink stalls.
    // TDATA is gated in IDLE so leftover state bits above OUT_BITS never leak out.
    always_comb begin
        M_TVALID = sending;
        M_TLAST  = sending && last_beat;
        M_TDATA  = sending ? shreg_q[DATA_WIDTH-1:0] : '0;
        busy     = sending;
        done     = done_q;
    end

endmodule

// File: tb/tb_axi_state_tx.sv
module tb_axi_state_tx;

    logic                  ACLK;
    logic                  rst;
    logic [4:0][4:0][63:0] d_in;
    logic                  start_sig [2];
    logic                  rdy_sig   [2];
    logic [15:0]           tdata     [2];
    logic                  vld       [2];
    logic                  last      [2];
    logic                  busy      [2];
    logic                  done      [2];

    int errors = 0;
    int checks = 0;
    bit en = 0;

    // index 0: full 1600-bit state, index 1: 256-bit digest prefix
    axi_state_tx #(.DATA_WIDTH(16), .OUT_BITS(1600)) dut_full (
        .ACLK(ACLK), .ARESET(rst), .start(start_sig[0]), .D_in(d_in),
        .M_TDATA(tdata[0]), .M_TVALID(vld[0]), .M_TREADY(rdy_sig[0]),
        .M_TLAST(last[0]), .busy(busy[0]), .done(done[0])
    );

    axi_state_tx #(.DATA_WIDTH(16), .OUT_BITS(256)) dut_dig (
        .ACLK(ACLK), .ARESET(rst), .start(start_sig[1]), .D_in(d_in),
        .M_TDATA(tdata[1]), .M_TVALID(vld[1]), .M_TREADY(rdy_sig[1]),
        .M_TLAST(last[1]), .busy(busy[1]), .done(done[1])
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0][4:0][63:0] pat(input logic [55:0] hi);
        logic [4:0][4:0][63:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {hi, 4'(x), 4'(y)};
        return r;
    endfunction

    function automatic logic [4:0][4:0][63:0] rnd_state();
        logic [4:0][4:0][63:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom, $urandom};
        return r;
    endfunction

    // ---------------- behavioural frame model ----------------
    bit          m_active [2] = '{0, 0};
    int          m_idx    [2] = '{0, 0};
    bit          m_done   [2] = '{0, 0};
    logic [1599:0] cap    [2];
    logic [1599:0] rx     [2];
    int          hs_cnt   [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    bit          p_vld    [2] = '{0, 0};
    bit          p_rdy    [2] = '{0, 0};
    logic [15:0] p_dat    [2];
    bit          p_last   [2] = '{0, 0};
    bit          p_rst = 1'b1;

    // Frame length in beats for each instance.
    function automatic int nbeats(input int k);
        return (k == 0) ? 100 : 16;
    endfunction

    task automatic chk_loopback(input int k);
        int n;
        int bad;
        n = nbeats(k);
        bad = -1;
        for (int i = n - 1; i >= 0; i--)
            if (rx[k][i*16 +: 16] !== cap[k][i*16 +: 16]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL loopback%0d: beat %0d got %0h expected %0h",
                     k, bad, rx[k][bad*16 +: 16], cap[k][bad*16 +: 16]);
        end
    endtask

    // Per-cycle compare, then advance the model using the inputs the next edge will sample.
    always @(negedge ACLK) begin
        for (int k = 0; k < 2; k++) begin
            string nm;
            nm = (k == 0) ? "full" : "dig";
            if (en) begin
                chk({nm, "_valid"}, 64'(vld[k]), 64'(m_active[k]));
                chk({nm, "_busy"},  64'(busy[k]), 64'(m_active[k]));
                chk({nm, "_done"},  64'(done[k]), 64'(m_done[k]));
                chk({nm, "_last"},  64'(last[k]),
                    64'(m_active[k] && (m_idx[k] == nbeats(k) - 1)));
                if (m_active[k])
                    chk({nm, "_data"}, 64'(tdata[k]), 64'(cap[k][m_idx[k]*16 +: 16]));
                if (p_vld[k] && !p_rdy[k] && !p_rst) begin
                    chk({nm, "_hold_valid"}, 64'(vld[k]), 64'(1));
                    chk({nm, "_hold_data"},  64'(tdata[k]), 64'(p_dat[k]));
                    chk({nm, "_hold_last"},  64'(last[k]), 64'(p_last[k]));
                end
                if (vld[k] && rdy_sig[k] && !rst) hs_cnt[k]++;
                if (done[k]) done_cnt[k]++;
            end
            p_vld[k]  = vld[k];
            p_rdy[k]  = rdy_sig[k];
            p_dat[k]  = tdata[k];
            p_last[k] = last[k];

            if (rst) begin
                m_active[k] = 0;
                m_idx[k]    = 0;
                m_done[k]   = 0;
            end else begin
                bit nd;
                nd = 0;
                if (m_active[k]) begin
                    if (rdy_sig[k]) begin
                        rx[k][m_idx[k]*16 +: 16] = tdata[k];
                        if (m_idx[k] == nbeats(k) - 1) begin
                            m_active[k] = 0;
                            nd = 1;
                            if (en) chk_loopback(k);
                        end else begin
                            m_idx[k]++;
                        end
                    end
                end else if (start_sig[k]) begin
                    cap[k]      = d_in;
                    rx[k]       = '0;
                    m_active[k] = 1;
                    m_idx[k]    = 0;
                end
                m_done[k] = nd;
            end
        end
        p_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_idle(input int k, input int budget, input string name);
        int n;
        n = 0;
        while (busy[k] && n < budget) begin
            rdy_sig[k] = ($urandom_range(0, 1) == 1);
            step();
            n++;
        end
        checks++;
        if (busy[k]) begin
            errors++;
            $display("FAIL %s: timeout still busy after %0d cycles", name, budget);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int dc0;
        int n;
        logic [4:0][4:0][63:0] dg;

        // 1: reset with start held high
        rst = 1; d_in = pat(56'h0123_4567_89AB_CD);
        start_sig[0] = 1; start_sig[1] = 1; rdy_sig[0] = 0; rdy_sig[1] = 0;
        step(); en = 1; step();
        rst = 0; start_sig[0] = 0; start_sig[1] = 0;
        @(negedge ACLK);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", 64'(vld[k]), 64'(0));
            chk("rst_busy",  64'(busy[k]), 64'(0));
            chk("rst_done",  64'(done[k]), 64'(0));
            chk("rst_last",  64'(last[k]), 64'(0));
            chk("rst_data",  64'(tdata[k]), 64'(0));
        end
        step(); step(); step();
        chk("rst_nostart", 64'(busy[0] | busy[1]), 64'(0));

        // 2: full rate, literal first/last beat and done timing
        rdy_sig[0] = 1; start_sig[0] = 1; d_in = pat(56'h0123_4567_89AB_CD);
        step();
        start_sig[0] = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge ACLK);
            if (j == 0)  chk("fr_beat0", 64'(tdata[0]), 64'h0000_0000_0000_CD00);
            if (j == 1)  chk("fr_beat1", 64'(tdata[0]), 64'h0000_0000_0000_89AB);
            if (j == 99) begin
                chk("fr_beat99", 64'(tdata[0]), 64'h0000_0000_0000_0123);
                chk("fr_last99", 64'(last[0]), 64'(1));
            end
        end
        @(negedge ACLK);
        chk("fr_done101",  64'(done[0]), 64'(1));
        chk("fr_valid101", 64'(vld[0]),  64'(0));
        @(negedge ACLK);
        chk("fr_done102",  64'(done[0]), 64'(0));
        step();

        // 3: random backpressure
        d_in = rnd_state(); start_sig[0] = 1; rdy_sig[0] = 0;
        hs0 = hs_cnt[0]; dc0 = done_cnt[0];
        step();
        start_sig[0] = 0;
        wait_idle(0, 2000, "bp_idle");
        step();
        chk("bp_beats", 64'(hs_cnt[0] - hs0), 64'(100));
        chk("bp_dones", 64'(done_cnt[0] - dc0), 64'(1));

        // 4: 256-bit digest prefix
        dg = pat(56'h0123_4567_89AB_CD);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (x > 0 || y == 4) dg[x][y] = '1;
        d_in = dg; rdy_sig[1] = 1; start_sig[1] = 1;
        step();
        start_sig[1] = 0;
        n = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge ACLK);
            if (tdata[1] == 16'hFFFF) n++;
            if (j == 12) chk("dg_beat12", 64'(tdata[1]), 64'h0000_0000_0000_CD03);
            if (j == 15) begin
                chk("dg_beat15", 64'(tdata[1]), 64'h0000_0000_0000_0123);
                chk("dg_last15", 64'(last[1]), 64'(1));
            end else begin
                chk("dg_nolast", 64'(last[1]), 64'(0));
            end
        end
        chk("dg_no_upper_lanes", 64'(n), 64'(0));
        @(negedge ACLK);
        chk("dg_done", 64'(done[1]), 64'(1));
        step();

        // 5: start pulses and D_in rewrites during a frame, restart in the done cycle
        rdy_sig[0] = 1; start_sig[0] = 1; d_in = pat(56'h1122_3344_5566_77);
        step();
        for (int i = 1; i < 100; i++) begin
            start_sig[0] = (i % 7 == 0);
            d_in = rnd_state();
            step();
        end
        start_sig[0] = 1; d_in = rnd_state();
        step();
        start_sig[0] = 1; d_in = pat(56'hFEDC_BA98_7654_32);
        step();
        start_sig[0] = 0; d_in = rnd_state();
        @(negedge ACLK);
        chk("b2b_valid", 64'(vld[0]), 64'(1));
        chk("b2b_beat0", 64'(tdata[0]), 64'h0000_0000_0000_3200);
        step();
        wait_idle(0, 2000, "b2b_idle");
        step();

        // 6: reset at beat 40, then a clean frame
        rdy_sig[0] = 1; start_sig[0] = 1; d_in = pat(56'h0123_4567_89AB_CD);
        step();
        start_sig[0] = 0;
        repeat (40) step();
        chk("ab_beat40", 64'(tdata[0]), 64'h0000_0000_0000_CD20);
        dc0 = done_cnt[0];
        rst = 1;
        step();
        rst = 0;
        @(negedge ACLK);
        chk("ab_valid", 64'(vld[0]), 64'(0));
        chk("ab_done",  64'(done[0]), 64'(0));
        @(negedge ACLK);
        chk("ab_done2", 64'(done[0]), 64'(0));
        step();
        chk("ab_nodone", 64'(done_cnt[0] - dc0), 64'(0));
        hs0 = hs_cnt[0];
        d_in = rnd_state(); start_sig[0] = 1;
        step();
        start_sig[0] = 0; d_in = rnd_state();
        @(negedge ACLK);
        chk("ab_restart_valid", 64'(vld[0]), 64'(1));
        step();
        wait_idle(0, 2000, "ab_idle");
        step(); step();
        chk("ab_beats", 64'(hs_cnt[0] - hs0), 64'(100));
        chk("ab_dones", 64'(done_cnt[0] - dc0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
